// File: rtl/wallace_mul8_seq.sv
// Sequential 8x8 unsigned multiplier: one 4x4 Wallace tree reused over four cycles,
// accumulating shifted nibble products into a 16-bit result.

module wallace_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  function automatic logic [15:0] csa(input logic [7:0] u, input logic [7:0] v, input logic [7:0] w);
    logic [7:0] s;
    logic [7:0] c;
    s = u ^ v ^ w;
    c = ((u & v) | (u & w) | (v & w)) << 1;
    return {s, c};
  endfunction

  logic [7:0] r0_s, r1_s, r2_s, r3_s;
  logic [15:0] l1_s, l2_s;

  // Partial-product rows reduced by two carry-save layers, then one carry-propagate add
  always_comb begin
    r0_s = {4'h0, x & {4{y[0]}}};
    r1_s = {3'h0, x & {4{y[1]}}, 1'b0};
    r2_s = {2'h0, x & {4{y[2]}}, 2'h0};
    r3_s = {1'b0, x & {4{y[3]}}, 3'h0};
    l1_s = csa(r0_s, r1_s, r2_s);
    l2_s = csa(l1_s[15:8], l1_s[7:0], r3_s);
    p    = l2_s[15:8] + l2_s[7:0];
  end
endmodule

module wallace_mul8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PP0  = 3'd1,
    S_PP1  = 3'd2,
    S_PP2  = 3'd3,
    S_PP3  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e      state_q;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc_q, acc_d;
  logic [15:0] product_q;
  logic        busy_q, done_q;
  logic [3:0]  x_s, y_s;
  logic [7:0]  pp_s;
  logic [15:0] pp_sh_s;

  wallace_4bit u_tree (
    .x (x_s),
    .y (y_s),
    .p (pp_s)
  );

  // Nibble selection and shift of the partial product for the current step
  always_comb begin
    x_s     = a_q[3:0];
    y_s     = b_q[3:0];
    pp_sh_s = {8'h00, pp_s};
    case (state_q)
      S_PP0: begin
        pp_sh_s = {8'h00, pp_s};
      end
      S_PP1: begin
        x_s     = a_q[7:4];
        pp_sh_s = {4'h0, pp_s, 4'h0};
      end
      S_PP2: begin
        y_s     = b_q[7:4];
        pp_sh_s = {4'h0, pp_s, 4'h0};
      end
      S_PP3: begin
        x_s     = a_q[7:4];
        y_s     = b_q[7:4];
        pp_sh_s = {pp_s, 8'h00};
      end
      default: begin
        pp_sh_s = {8'h00, pp_s};
      end
    endcase
    acc_d = acc_q + pp_sh_s;
  end

  // Control FSM with registered busy/done/product; DONE doubles as an accept cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      acc_q     <= 16'h0000;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= 16'h0000;
            busy_q  <= 1'b1;
            state_q <= S_PP0;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_PP0: begin
          acc_q   <= acc_d;
          state_q <= S_PP1;
        end
        S_PP1: begin
          acc_q   <= acc_d;
          state_q <= S_PP2;
        end
        S_PP2: begin
          acc_q   <= acc_d;
          state_q <= S_PP3;
        end
        S_PP3: begin
          acc_q     <= acc_d;
          product_q <= acc_d;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_wallace_mul8_seq.sv
// Randomized self-checking bench for wallace_mul8_seq against a plain a*b reference.

module tb_wallace_mul8_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks_r = 0;
  int errors_r = 0;
  int done_cnt_r = 0;

  wallace_mul8_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Count done pulses and verify busy/done exclusivity every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (done === 1'b1) done_cnt_r++;
      check_val("busy_done_excl", {31'd0, busy & done}, 32'd0);
    end
  end

  // Issue one multiply and wait for done; x/y are the operands, inputs scrambled while busy
  task automatic run_mul(input logic [7:0] x, input logic [7:0] y);
    int busy_cyc;
    int d0;
    logic seen;
    logic [15:0] prev;
    logic changed;
    logic [15:0] exp_p;
    exp_p   = 16'(x) * 16'(y);
    prev    = product;
    changed = 1'b0;
    seen    = 1'b0;
    busy_cyc = 0;
    d0 = done_cnt_r;
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
      if (product !== prev) changed = 1'b1;
      a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
    end
    check_val("done_seen", {31'd0, seen}, 32'd1);
    check_val("busy_cycles", busy_cyc, 32'd4);
    check_val("prod_hold", {31'd0, changed}, 32'd0);
    check_val("product", {16'd0, product}, {16'd0, exp_p});
    @(negedge clk);
    check_val("done_one_cycle", {31'd0, done}, 32'd0);
    check_val("idle_not_busy", {31'd0, busy}, 32'd0);
    check_val("done_count", done_cnt_r - d0, 32'd1);
  endtask

  initial begin
    int d0;
    int waited;
    logic [7:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_mul(8'hFF, 8'hFF);
    run_mul(8'd200, 8'd150);
    run_mul(8'h00, 8'hAB);

    // Back-to-back with start held: second accept on the DONE edge
    a = 8'd3; b = 8'd2; start = 1'b1;
    @(negedge clk);
    waited = 0;
    while (done !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_val("b2b_first_done", {31'd0, done}, 32'd1);
    check_val("b2b_first_prod", {16'd0, product}, 32'd6);
    check_val("b2b_first_lat", waited, 32'd4);
    a = 8'd5; b = 8'd3;
    @(negedge clk);
    check_val("b2b_no_idle", {31'd0, busy}, 32'd1);
    check_val("b2b_done_low", {31'd0, done}, 32'd0);
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    start = 1'b0;
    check_val("b2b_second_done", {31'd0, done}, 32'd1);
    check_val("b2b_second_prod", {16'd0, product}, 32'd15);
    @(negedge clk);

    // start during PP1 must be ignored
    d0 = done_cnt_r;
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    check_val("ignore_prod", {16'd0, product}, 32'h03A8);
    check_val("ignore_done_cnt", done_cnt_r - d0, 32'd1);
    check_val("ignore_idle", {31'd0, busy}, 32'd0);

    // Reset during PP2
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_done", {31'd0, done}, 32'd0);
    check_val("midrst_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("post_rst_quiet", {30'd0, busy, done}, 32'd0);
    end
    run_mul(8'd7, 8'd9);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_mul(ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/wallace_mul8_seq.md
# wallace_mul8_seq

Sequential 8x8 unsigned multiplier controller. It time-shares a single `wallace_4bit` combinational 4x4 multiplier across four cycles. Each cycle it feeds one pair of operand nibbles and accumulates the shifted 8-bit partial product into a 16-bit result. It sits between the datapath issue logic and the existing `wallace_4bit` instance, giving 8-bit multiply capability without a second tree.

## Interface
Parameters:
- None. Widths are fixed: 8-bit operands, 4x4->8 sub-multiplier, 16-bit product.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a multiply; sampled only in IDLE or DONE.
- `a` input 8: multiplicand, unsigned; latched when start is accepted.
- `b` input 8: multiplier, unsigned; latched when start is accepted.
- `busy` output 1: high in PP0..PP3.
- `done` output 1: high for exactly one cycle (DONE state) when `product` is newly valid.
- `product` output 16: registered result; holds its value until the next accepted operation completes.

## Operation
- Internal: one `wallace_4bit` instance, operand registers `a_q`/`b_q` (8 each), accumulator `acc` (16), state register.
- States: IDLE, PP0, PP1, PP2, PP3, DONE.
- IDLE with start=1:
  - latch a_q<=a, b_q<=b;
  - acc<=0;
  - go to PP0.
- IDLE with start=0: stay in IDLE.
- Nibble feed to `wallace_4bit` (x, y) and accumulation per state:
  - PP0: (a_q[3:0], b_q[3:0]); acc += pp.
  - PP1: (a_q[7:4], b_q[3:0]); acc += pp<<4.
  - PP2: (a_q[3:0], b_q[7:4]); acc += pp<<4.
  - PP3: (a_q[7:4], b_q[7:4]); acc += pp<<8.
- Arithmetic:
  - pp is zero-extended to 16 bits before the shift.
  - All adds are 16-bit unsigned. The final sum never exceeds 0xFE01, so there is no overflow handling.
- PP3 -> DONE: product<=acc+(pp<<8). The final sum is written directly to `product`.
- DONE: done=1.
  - start=1: accept new operands, acc<=0, go to PP0 (back-to-back, no IDLE bubble).
  - start=0: go to IDLE.
- start while busy (PP0..PP3): ignored. Operands, acc and sequence are unaffected, and no queueing occurs.
- In IDLE/DONE the nibble inputs to `wallace_4bit` are don't-care. Its output is unused.

## Timing
- Reset (rst_n=0, asynchronous), taking effect immediately:
  - state=IDLE, busy=0, done=0, product=0x0000;
  - a_q=0, b_q=0, acc=0.
- Reset mid-operation (any state): the operation is abandoned with no done pulse, and product returns to 0.
- Release: first accept possible at the first rising edge with rst_n=1 and start=1.
- Latency: start accepted at edge E0.
  - busy=1 from after E0 through E4.
  - PP0..PP3 occupy the cycles after E0..E3.
  - product is updated and done=1 after edge E4, for one cycle.
  - Start-to-done is 4 cycles.
- Throughput: one multiply per 5 cycles with start held, because the DONE cycle doubles as the accept cycle.
- done and busy are never high simultaneously.
- product changes only on the PP3->DONE edge or on reset.

## Test plan
- Reset then a=0xFF, b=0xFF, start pulse -> busy high 4 cycles, done pulse 4 cycles after accept, product=0xFE01.
- a=200, b=150 -> product=30000 (0x7530). Then a=0x00, b=0xAB -> product=0x0000, done still pulses.
- start held high with a=3, b=2 then a=5, b=3 presented in the DONE cycle:
  - product=6 with done;
  - next accept happens at that same edge;
  - product=15 five cycles later;
  - no IDLE cycle in between.
- Accept a=0x12, b=0x34; during PP1 drive start=1, a=0xFF, b=0xFF -> ignored, product=0x03A8, only one done pulse.
- Accept a=0x80, b=0x80; assert rst_n=0 during PP2 -> busy/done/product immediately 0, state IDLE. After release, a=7, b=9 gives product=63.
- Random sweep: 1000 random (a, b) pairs, each product == a*b, exactly one done per accepted start.
